// File: rtl/operand_pair_pkg.sv
// Shared types for the operand pair collector: pairing FSM states and FIFO entry width.
// Entry width grows by one carry bit when OPERAND_PAIR_COLLECTOR_CARRY_EN is defined.
package operand_pair_pkg;

   typedef enum logic {
      ST_IDLE       = 1'b0,
      ST_HAVE_FIRST = 1'b1
   } state_e;

   function automatic int unsigned pair_entry_w(input int unsigned width);
`ifdef OPERAND_PAIR_COLLECTOR_CARRY_EN
      return 2 * width + 1;
`else
      return 2 * width;
`endif
   endfunction

endpackage

// File: rtl/pair_fifo.sv
// Synchronous FIFO with flush, occupancy count and a head output that reads as zero when empty.
module pair_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_q + CW'(push_i) - CW'(pop_i);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i && !flush_i) mem[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = (count_q == '0) ? '0 : mem[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/operand_pair_collector.sv
// Collects a serial operand stream into (A, B) pairs buffered in a FIFO for the compute stage.
// Define OPERAND_PAIR_COLLECTOR_CARRY_EN to add pair_carry_o (carry-out of A+B per entry).
module operand_pair_collector
   import operand_pair_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   flush_i,
   input  logic                   op_valid_i,
   output logic                   op_ready_o,
   input  logic [WIDTH-1:0]       op_data_i,
   output logic                   pair_valid_o,
   input  logic                   pair_ready_i,
   output logic [WIDTH-1:0]       pair_a_o,
   output logic [WIDTH-1:0]       pair_b_o,
   output logic [$clog2(DEPTH):0] count_o
`ifdef OPERAND_PAIR_COLLECTOR_CARRY_EN
   ,
   output logic                   pair_carry_o
`endif
);

   localparam int unsigned EW = pair_entry_w(WIDTH);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   state_e           state_q;
   state_e           state_d;
   logic [WIDTH-1:0] hold_q;
   logic             hold_en;
   logic             push;
   logic             pop;
   logic [EW-1:0]    entry;
   logic [EW-1:0]    head;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Ready depends only on registered state and count; a held A never waits on FIFO space.
   always_comb begin
      state_d    = state_q;
      op_ready_o = 1'b1;
      hold_en    = 1'b0;
      push       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (op_valid_i && !flush_i) begin
               hold_en = 1'b1;
               state_d = ST_HAVE_FIRST;
            end
         end
         ST_HAVE_FIRST: begin
            op_ready_o = (count_o != CW'(DEPTH));
            if (op_valid_i && op_ready_o && !flush_i) begin
               push    = 1'b1;
               state_d = ST_IDLE;
            end
         end
      endcase
      if (flush_i) state_d = ST_IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)      hold_q <= '0;
      else if (hold_en) hold_q <= op_data_i;
   end

`ifdef OPERAND_PAIR_COLLECTOR_CARRY_EN
   logic [WIDTH:0] sum;
   assign sum   = {1'b0, hold_q} + {1'b0, op_data_i};
   assign entry = {sum[WIDTH], hold_q, op_data_i};
`else
   assign entry = {hold_q, op_data_i};
`endif

   assign pop = pair_valid_o && pair_ready_i;

   pair_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (entry),
      .rdata_o (head),
      .count_o (count_o)
   );

   assign pair_valid_o = (count_o != '0);
   assign pair_a_o     = head[2*WIDTH-1:WIDTH];
   assign pair_b_o     = head[WIDTH-1:0];
`ifdef OPERAND_PAIR_COLLECTOR_CARRY_EN
   assign pair_carry_o = head[2*WIDTH];
`endif

endmodule

// File: tb/tb_operand_pair_collector.sv
// Bench for operand_pair_collector: directed scenarios plus random traffic against a queue model.
module tb_operand_pair_collector;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   logic             clk_i;
   logic             rst_ni;
   logic             flush_i;
   logic             op_valid_i;
   logic             op_ready_o;
   logic [WIDTH-1:0] op_data_i;
   logic             pair_valid_o;
   logic             pair_ready_i;
   logic [WIDTH-1:0] pair_a_o;
   logic [WIDTH-1:0] pair_b_o;
   logic [CW-1:0]    count_o;
`ifdef OPERAND_PAIR_COLLECTOR_CARRY_EN
   logic             pair_carry_o;
`endif

   operand_pair_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .flush_i      (flush_i),
      .op_valid_i   (op_valid_i),
      .op_ready_o   (op_ready_o),
      .op_data_i    (op_data_i),
      .pair_valid_o (pair_valid_o),
      .pair_ready_i (pair_ready_i),
      .pair_a_o     (pair_a_o),
      .pair_b_o     (pair_b_o),
      .count_o      (count_o)
`ifdef OPERAND_PAIR_COLLECTOR_CARRY_EN
      ,
      .pair_carry_o (pair_carry_o)
`endif
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: an optional held first operand and a queue of {A,B} pairs.
   logic [2*WIDTH-1:0] mq[$];
   bit                 m_held;
   logic [WIDTH-1:0]   m_hold;
   bit                 m_acc;
   bit                 m_pop;

   function automatic bit m_ready();
      return !m_held || (mq.size() < DEPTH);
   endfunction

   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mq.delete();
         m_held = 1'b0;
         m_hold = '0;
      end else if (flush_i) begin
         mq.delete();
         m_held = 1'b0;
      end else begin
         m_acc = op_valid_i && m_ready();
         m_pop = (mq.size() != 0) && pair_ready_i;
         if (m_pop) void'(mq.pop_front());
         if (m_acc) begin
            if (!m_held) begin
               m_held = 1'b1;
               m_hold = op_data_i;
            end else begin
               mq.push_back({m_hold, op_data_i});
               m_held = 1'b0;
            end
         end
      end
   end

   logic [2*WIDTH-1:0] exp_head;
   logic [WIDTH:0]     exp_sum;

   always @(negedge clk_i) begin
      if (rst_ni) begin
         exp_head = (mq.size() != 0) ? mq[0] : '0;
         exp_sum  = {1'b0, exp_head[2*WIDTH-1:WIDTH]} + {1'b0, exp_head[WIDTH-1:0]};
         check("op_ready",   32'(op_ready_o),   32'(m_ready()));
         check("pair_valid", 32'(pair_valid_o), 32'(mq.size() != 0));
         check("count",      32'(count_o),      32'(mq.size()));
         check("pair_a",     32'(pair_a_o),     32'(exp_head[2*WIDTH-1:WIDTH]));
         check("pair_b",     32'(pair_b_o),     32'(exp_head[WIDTH-1:0]));
`ifdef OPERAND_PAIR_COLLECTOR_CARRY_EN
         check("pair_carry", 32'(pair_carry_o), 32'((mq.size() != 0) ? exp_sum[WIDTH] : 1'b0));
`endif
      end
   end

   task automatic step();
      @(negedge clk_i);
      #2;
   endtask

   task automatic send(input logic [WIDTH-1:0] d);
      op_valid_i = 1'b1;
      op_data_i  = d;
      for (int i = 0; i < 50; i++) begin
         if (op_ready_o) begin
            step();
            op_valid_i = 1'b0;
            return;
         end
         step();
      end
      check("send_timeout", 32'(0), 32'(1));
      op_valid_i = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_op_ready"},   32'(op_ready_o),   32'(1));
      check({tag, "_pair_valid"}, 32'(pair_valid_o), 32'(0));
      check({tag, "_count"},      32'(count_o),      32'(0));
      check({tag, "_pair_a"},     32'(pair_a_o),     32'(0));
      check({tag, "_pair_b"},     32'(pair_b_o),     32'(0));
`ifdef OPERAND_PAIR_COLLECTOR_CARRY_EN
      check({tag, "_carry"},      32'(pair_carry_o), 32'(0));
`endif
   endtask

   initial begin
      rst_ni       = 1'b0;
      flush_i      = 1'b0;
      op_valid_i   = 1'b0;
      op_data_i    = '0;
      pair_ready_i = 1'b0;
      #1;
      check_reset_values("reset");
      repeat (2) @(negedge clk_i);
      #2 rst_ni = 1'b1;
      step();

      // Single pair through an always-ready consumer.
      pair_ready_i = 1'b1;
      send(8'h12);
      send(8'h34);
      check("t1_valid", 32'(pair_valid_o), 32'(1));
      check("t1_a",     32'(pair_a_o),     32'h12);
      check("t1_b",     32'(pair_b_o),     32'h34);
      check("t1_count", 32'(count_o),      32'(1));
      step();
      check("t1_drain", 32'(count_o),      32'(0));

      // Fill to full, hold a ninth operand, tenth stalls.
      pair_ready_i = 1'b0;
      for (int i = 0; i < 9; i++) send(8'(8'hA0 + i));
      check("t2_full",  32'(count_o),    32'(4));
      check("t2_stall", 32'(op_ready_o), 32'(0));
      op_valid_i = 1'b1;
      op_data_i  = 8'hA9;
      step();
      check("t2_still_stall", 32'(op_ready_o), 32'(0));
      check("t2_still_full",  32'(count_o),    32'(4));

      // Pop at full with a pending second operand: no push this edge.
      pair_ready_i = 1'b1;
      step();
      check("t3_pop_only", 32'(count_o),    32'(3));
      check("t3_ready",    32'(op_ready_o), 32'(1));
      step();
      op_valid_i = 1'b0;
      check("t3_push_pop", 32'(count_o),  32'(3));
      check("t3_head_a",   32'(pair_a_o), 32'hA4);
      check("t3_head_b",   32'(pair_b_o), 32'hA5);
      repeat (4) step();
      check("t3_empty", 32'(count_o), 32'(0));

      // Flush with two pairs buffered and A=0x55 held.
      pair_ready_i = 1'b0;
      send(8'hB0); send(8'hB1); send(8'hB2); send(8'hB3); send(8'h55);
      check("t4_pre", 32'(count_o), 32'(2));
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      check("t4_count", 32'(count_o),      32'(0));
      check("t4_valid", 32'(pair_valid_o), 32'(0));
      check("t4_ready", 32'(op_ready_o),   32'(1));
      send(8'h01);
      send(8'h02);
      check("t4_a", 32'(pair_a_o), 32'h01);
      check("t4_b", 32'(pair_b_o), 32'h02);
      pair_ready_i = 1'b1;
      step();

`ifdef OPERAND_PAIR_COLLECTOR_CARRY_EN
      send(8'hFF);
      send(8'h01);
      check("t5_carry1", 32'(pair_carry_o), 32'(1));
      send(8'h7F);
      send(8'h01);
      check("t5_carry0", 32'(pair_carry_o), 32'(0));
      step();
`endif

      // Asynchronous reset with a pair pending.
      pair_ready_i = 1'b0;
      send(8'h21);
      send(8'h22);
      check("t6_pending", 32'(pair_valid_o), 32'(1));
      @(negedge clk_i);
      #3 rst_ni = 1'b0;
      #1;
      check_reset_values("async");
      @(negedge clk_i);
      #2 rst_ni = 1'b1;
      step();
      send(8'h03);
      send(8'h04);
      check("t6_a", 32'(pair_a_o), 32'h03);
      check("t6_b", 32'(pair_b_o), 32'h04);

      // Random traffic with phases of slow and fast consumer.
      for (int c = 0; c < 3000; c++) begin
         op_valid_i   = ($urandom_range(0, 3) != 0);
         op_data_i    = 8'($urandom);
         pair_ready_i = ((c / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0)
                                             : ($urandom_range(0, 3) != 0);
         flush_i      = ($urandom_range(0, 99) == 0);
         step();
      end
      op_valid_i = 1'b0;
      flush_i    = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
